// File: rtl/voice_allocator.sv
// Note-event voice scheduler: serially scans VOICES slots and issues key/velocity load strobes.
// Optional macro VOICE_STEAL_EN enables stealing the oldest held voice; otherwise such notes are dropped.
module voice_allocator #(
  parameter int VOICES  = 4,
  parameter int V_WIDTH = (VOICES > 1) ? $clog2(VOICES) : 1,
  parameter int AGE_W   = 8
) (
  input  logic               CLOCK_25,
  input  logic               reset,
  input  logic               ev_valid,
  output logic               ev_ready,
  input  logic               ev_on,
  input  logic [6:0]         ev_key,
  input  logic [6:0]         ev_vel,
  input  logic [VOICES-1:0]  voice_free,
  output logic [VOICES-1:0]  keys_on,
  output logic               note_on,
  output logic               note_off,
  output logic [V_WIDTH-1:0] cur_key_adr,
  output logic [7:0]         cur_key_val,
  output logic [7:0]         cur_vel_on,
  output logic [7:0]         cur_vel_off,
  output logic [V_WIDTH:0]   active_keys,
  output logic               off_note_error,
  output logic               stolen
);

  localparam int LAST = VOICES - 1;

  typedef enum logic [1:0] {IDLE, SCAN, ISSUE} state_t;

  state_t             state_q;
  logic [V_WIDTH-1:0] idx_q;
  logic               evOn_q;
  logic [6:0]         evKey_q;
  logic [6:0]         evVel_q;

  logic               matchFound_q, freeFound_q, relFound_q;
  logic [V_WIDTH-1:0] matchIdx_q, freeIdx_q, relIdx_q;
`ifdef VOICE_STEAL_EN
  logic               oldFound_q;
  logic [V_WIDTH-1:0] oldIdx_q;
  logic [AGE_W-1:0]   oldAge_q;
`endif

  logic [6:0]         tag_q [VOICES];
  logic [AGE_W-1:0]   age_q [VOICES];
  logic [VOICES-1:0]  keys_on_q, keys_on_d;
  logic [V_WIDTH:0]   active_q, active_d;

  logic               noteOn_q, noteOff_q, offErr_q, stolen_q;
  logic [V_WIDTH-1:0] curAdr_q;
  logic [7:0]         curVal_q, curVelOn_q, curVelOff_q;

  logic               issueOn_d, issueOff_d, issueErr_d, issueFlag_d;
  logic [V_WIDTH-1:0] target_d;

  // Resolve the recorded scan candidates into the action taken in ISSUE.
  always_comb begin
    issueOn_d   = 1'b0;
    issueOff_d  = 1'b0;
    issueErr_d  = 1'b0;
    issueFlag_d = 1'b0;
    target_d    = '0;
    keys_on_d   = keys_on_q;
    if (state_q == ISSUE) begin
      if (evOn_q) begin
        if (matchFound_q) begin
          issueOn_d = 1'b1;
          target_d  = matchIdx_q;
        end else if (freeFound_q) begin
          issueOn_d = 1'b1;
          target_d  = freeIdx_q;
        end else if (relFound_q) begin
          issueOn_d = 1'b1;
          target_d  = relIdx_q;
        end else begin
`ifdef VOICE_STEAL_EN
          issueOn_d   = 1'b1;
          issueFlag_d = 1'b1;
          target_d    = oldIdx_q;
`else
          issueFlag_d = 1'b1;
`endif
        end
        if (issueOn_d) keys_on_d[target_d] = 1'b1;
      end else if (matchFound_q) begin
        issueOff_d            = 1'b1;
        target_d              = matchIdx_q;
        keys_on_d[target_d]   = 1'b0;
      end else begin
        issueErr_d = 1'b1;
      end
    end
  end

  always_comb begin
    active_d = '0;
    for (int i = 0; i < VOICES; i++) active_d = active_d + (V_WIDTH+1)'(keys_on_d[i]);
  end

  always_ff @(posedge CLOCK_25) begin
    if (reset) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      evOn_q       <= 1'b0;
      evKey_q      <= '0;
      evVel_q      <= '0;
      matchFound_q <= 1'b0;
      freeFound_q  <= 1'b0;
      relFound_q   <= 1'b0;
      matchIdx_q   <= '0;
      freeIdx_q    <= '0;
      relIdx_q     <= '0;
`ifdef VOICE_STEAL_EN
      oldFound_q   <= 1'b0;
      oldIdx_q     <= '0;
      oldAge_q     <= '0;
`endif
      for (int i = 0; i < VOICES; i++) begin
        tag_q[i] <= '0;
        age_q[i] <= '0;
      end
      keys_on_q    <= '0;
      active_q     <= '0;
      noteOn_q     <= 1'b0;
      noteOff_q    <= 1'b0;
      offErr_q     <= 1'b0;
      stolen_q     <= 1'b0;
      curAdr_q     <= '0;
      curVal_q     <= '0;
      curVelOn_q   <= '0;
      curVelOff_q  <= '0;
    end else begin
      noteOn_q  <= issueOn_d;
      noteOff_q <= issueOff_d;
      offErr_q  <= issueErr_d;
      stolen_q  <= issueFlag_d;
      case (state_q)
        IDLE: begin
          if (ev_valid) begin
            // Velocity 0 on a note-on is the running-status form of note-off.
            evOn_q       <= ev_on && (ev_vel != 7'd0);
            evKey_q      <= ev_key;
            evVel_q      <= ev_vel;
            matchFound_q <= 1'b0;
            freeFound_q  <= 1'b0;
            relFound_q   <= 1'b0;
`ifdef VOICE_STEAL_EN
            oldFound_q   <= 1'b0;
`endif
            idx_q        <= '0;
            state_q      <= SCAN;
          end
        end
        SCAN: begin
          if (keys_on_q[idx_q] && tag_q[idx_q] == evKey_q && !matchFound_q) begin
            matchFound_q <= 1'b1;
            matchIdx_q   <= idx_q;
          end
          if (!keys_on_q[idx_q] && voice_free[idx_q] && !freeFound_q) begin
            freeFound_q <= 1'b1;
            freeIdx_q   <= idx_q;
          end
          if (!keys_on_q[idx_q] && !relFound_q) begin
            relFound_q <= 1'b1;
            relIdx_q   <= idx_q;
          end
`ifdef VOICE_STEAL_EN
          // Strict compare keeps the lowest index among equally old voices.
          if (keys_on_q[idx_q] && (!oldFound_q || age_q[idx_q] > oldAge_q)) begin
            oldFound_q <= 1'b1;
            oldIdx_q   <= idx_q;
            oldAge_q   <= age_q[idx_q];
          end
`endif
          if (idx_q == V_WIDTH'(LAST)) state_q <= ISSUE;
          else idx_q <= idx_q + V_WIDTH'(1);
        end
        ISSUE: begin
          state_q   <= IDLE;
          keys_on_q <= keys_on_d;
          active_q  <= active_d;
          for (int i = 0; i < VOICES; i++) begin
            if (issueOn_d && V_WIDTH'(i) == target_d) begin
              tag_q[i] <= evKey_q;
              age_q[i] <= '0;
            end else if (issueOn_d && keys_on_q[i] && age_q[i] != {AGE_W{1'b1}}) begin
              age_q[i] <= age_q[i] + AGE_W'(1);
            end
          end
          if (issueOn_d) begin
            curAdr_q   <= target_d;
            curVal_q   <= {1'b0, evKey_q};
            curVelOn_q <= {1'b0, evVel_q};
          end
          if (issueOff_d) begin
            curAdr_q    <= target_d;
            curVal_q    <= {1'b0, evKey_q};
            curVelOff_q <= {1'b0, evVel_q};
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ev_ready       = (state_q == IDLE);
  assign keys_on        = keys_on_q;
  assign active_keys    = active_q;
  assign note_on        = noteOn_q;
  assign note_off       = noteOff_q;
  assign off_note_error = offErr_q;
  assign stolen         = stolen_q;
  assign cur_key_adr    = curAdr_q;
  assign cur_key_val    = curVal_q;
  assign cur_vel_on     = curVelOn_q;
  assign cur_vel_off    = curVelOff_q;

endmodule

// File: tb/tb_voice_allocator.sv
// Scoreboard bench for voice_allocator (VOICES=4): directed note events, monitor checks each output pulse.
module tb_voice_allocator;

  localparam int VOICES = 4;
`ifdef VOICE_STEAL_EN
  localparam logic [6:0] V0_KEY = 7'd67;
`else
  localparam logic [6:0] V0_KEY = 7'd60;
`endif

  logic        CLOCK_25 = 1'b0;
  logic        reset = 1'b1;
  logic        ev_valid = 1'b0;
  logic        ev_ready;
  logic        ev_on = 1'b0;
  logic [6:0]  ev_key = '0;
  logic [6:0]  ev_vel = '0;
  logic [3:0]  voice_free = '0;
  logic [3:0]  keys_on;
  logic        note_on, note_off, off_note_error, stolen;
  logic [1:0]  cur_key_adr;
  logic [7:0]  cur_key_val, cur_vel_on, cur_vel_off;
  logic [2:0]  active_keys;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [3:0] pulses;
    logic [1:0] adr;
    logic [7:0] keyVal;
    logic [7:0] vel;
    logic [3:0] keys;
    logic [2:0] act;
    bit         isOn;
    bit         isOff;
  } expT;

  expT sbQ[$];

  voice_allocator #(.VOICES(VOICES)) dut (
    .CLOCK_25(CLOCK_25), .reset(reset), .ev_valid(ev_valid), .ev_ready(ev_ready),
    .ev_on(ev_on), .ev_key(ev_key), .ev_vel(ev_vel), .voice_free(voice_free),
    .keys_on(keys_on), .note_on(note_on), .note_off(note_off),
    .cur_key_adr(cur_key_adr), .cur_key_val(cur_key_val), .cur_vel_on(cur_vel_on),
    .cur_vel_off(cur_vel_off), .active_keys(active_keys),
    .off_note_error(off_note_error), .stolen(stolen)
  );

  always #5 CLOCK_25 = ~CLOCK_25;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected-response builders, pulses ordered {note_on, note_off, off_note_error, stolen}.
  function automatic expT mkOn(input logic [1:0] adr, input logic [6:0] key, input logic [6:0] vel,
                               input bit stl, input logic [3:0] keys, input logic [2:0] act);
    expT e;
    e.pulses = {1'b1, 1'b0, 1'b0, stl};
    e.adr = adr; e.keyVal = {1'b0, key}; e.vel = {1'b0, vel};
    e.keys = keys; e.act = act; e.isOn = 1'b1; e.isOff = 1'b0;
    return e;
  endfunction

  function automatic expT mkOff(input logic [1:0] adr, input logic [6:0] key, input logic [6:0] vel,
                                input logic [3:0] keys, input logic [2:0] act);
    expT e;
    e.pulses = 4'b0100;
    e.adr = adr; e.keyVal = {1'b0, key}; e.vel = {1'b0, vel};
    e.keys = keys; e.act = act; e.isOn = 1'b0; e.isOff = 1'b1;
    return e;
  endfunction

  function automatic expT mkFlag(input logic [3:0] pulses, input logic [3:0] keys, input logic [2:0] act);
    expT e;
    e.pulses = pulses;
    e.adr = '0; e.keyVal = '0; e.vel = '0;
    e.keys = keys; e.act = act; e.isOn = 1'b0; e.isOff = 1'b0;
    return e;
  endfunction

  // Issue one event and check the accept-to-ready latency; the pulse itself is checked by the monitor.
  task automatic applyStimulus(input bit on, input logic [6:0] key, input logic [6:0] vel,
                               input expT exp, input bit expectPulse);
    int n;
    if (expectPulse) sbQ.push_back(exp);
    @(negedge CLOCK_25);
    ev_valid = 1'b1; ev_on = on; ev_key = key; ev_vel = vel;
    n = 0;
    while (!ev_ready && n < 50) begin
      @(negedge CLOCK_25);
      n++;
    end
    @(posedge CLOCK_25);
    #1 ev_valid = 1'b0;
    n = 0;
    do begin
      @(negedge CLOCK_25);
      n++;
    end while (!ev_ready && n < 50);
    checkOutput("latency", n, VOICES + 2);
  endtask

  task automatic doReset();
    reset = 1'b1;
    repeat (3) @(negedge CLOCK_25);
    reset = 1'b0;
  endtask

  // Monitor: every output pulse pops one expected response.
  initial begin
    expT e;
    forever begin
      @(negedge CLOCK_25);
      if (!reset && (note_on || note_off || off_note_error || stolen)) begin
        if (sbQ.size() == 0) begin
          checkOutput("unexpected_pulse", {28'd0, note_on, note_off, off_note_error, stolen}, 0);
        end else begin
          e = sbQ.pop_front();
          checkOutput("pulses", {28'd0, note_on, note_off, off_note_error, stolen}, {28'd0, e.pulses});
          checkOutput("keys_on", {28'd0, keys_on}, {28'd0, e.keys});
          checkOutput("active_keys", {29'd0, active_keys}, {29'd0, e.act});
          if (e.isOn || e.isOff) begin
            checkOutput("cur_key_adr", {30'd0, cur_key_adr}, {30'd0, e.adr});
            checkOutput("cur_key_val", {24'd0, cur_key_val}, {24'd0, e.keyVal});
          end
          if (e.isOn) checkOutput("cur_vel_on", {24'd0, cur_vel_on}, {24'd0, e.vel});
          if (e.isOff) checkOutput("cur_vel_off", {24'd0, cur_vel_off}, {24'd0, e.vel});
        end
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    expT none;
    none = mkFlag(4'b0000, 4'b0000, 3'd0);
    $display("[TB] voice_allocator bench start");
    doReset();
    checkOutput("rst_ev_ready", {31'd0, ev_ready}, 1);
    checkOutput("rst_keys_on", {28'd0, keys_on}, 0);
    checkOutput("rst_active", {29'd0, active_keys}, 0);
    checkOutput("rst_pulses", {28'd0, note_on, note_off, off_note_error, stolen}, 0);
    checkOutput("rst_cur", {14'd0, cur_key_adr, cur_key_val, cur_vel_on}, 0);

    voice_free = 4'b1111;
    applyStimulus(1, 7'd60, 7'd100, mkOn(2'd0, 7'd60, 7'd100, 0, 4'b0001, 3'd1), 1);
    applyStimulus(1, 7'd60, 7'd50,  mkOn(2'd0, 7'd60, 7'd50,  0, 4'b0001, 3'd1), 1);
    applyStimulus(1, 7'd62, 7'd90,  mkOn(2'd1, 7'd62, 7'd90,  0, 4'b0011, 3'd2), 1);
    applyStimulus(1, 7'd64, 7'd80,  mkOn(2'd2, 7'd64, 7'd80,  0, 4'b0111, 3'd3), 1);
    applyStimulus(1, 7'd65, 7'd70,  mkOn(2'd3, 7'd65, 7'd70,  0, 4'b1111, 3'd4), 1);
`ifdef VOICE_STEAL_EN
    applyStimulus(1, 7'd67, 7'd60,  mkOn(2'd0, 7'd67, 7'd60,  1, 4'b1111, 3'd4), 1);
`else
    applyStimulus(1, 7'd67, 7'd60,  mkFlag(4'b0001, 4'b1111, 3'd4), 1);
`endif
    applyStimulus(0, 7'd62, 7'd40,  mkOff(2'd1, 7'd62, 7'd40, 4'b1101, 3'd3), 1);
    applyStimulus(0, 7'd62, 7'd40,  mkFlag(4'b0010, 4'b1101, 3'd3), 1);
    applyStimulus(0, V0_KEY, 7'd0,  mkOff(2'd0, V0_KEY, 7'd0, 4'b1100, 3'd2), 1);

    voice_free = 4'b0010;
    applyStimulus(1, 7'd70, 7'd20,  mkOn(2'd1, 7'd70, 7'd20,  0, 4'b1110, 3'd3), 1);
    applyStimulus(1, 7'd64, 7'd0,   mkOff(2'd2, 7'd64, 7'd0, 4'b1010, 3'd2), 1);
    voice_free = 4'b0000;
    applyStimulus(1, 7'd72, 7'd30,  mkOn(2'd0, 7'd72, 7'd30,  0, 4'b1011, 3'd3), 1);

    // Reset in the middle of a scan must abort the event silently.
    voice_free = 4'b1111;
    @(negedge CLOCK_25);
    ev_valid = 1'b1; ev_on = 1'b1; ev_key = 7'd80; ev_vel = 7'd10;
    @(posedge CLOCK_25);
    #1 ev_valid = 1'b0;
    @(negedge CLOCK_25);
    @(negedge CLOCK_25);
    reset = 1'b1;
    @(negedge CLOCK_25);
    reset = 1'b0;
    @(negedge CLOCK_25);
    checkOutput("abort_ev_ready", {31'd0, ev_ready}, 1);
    checkOutput("abort_keys_on", {28'd0, keys_on}, 0);
    checkOutput("abort_active", {29'd0, active_keys}, 0);
    repeat (8) @(negedge CLOCK_25);

    applyStimulus(1, 7'd60, 7'd100, mkOn(2'd0, 7'd60, 7'd100, 0, 4'b0001, 3'd1), 1);
    applyStimulus(0, 7'd99, 7'd5,   mkFlag(4'b0010, 4'b0001, 3'd1), 1);
    if (none.keys != 4'b0000) $display("[TB] note: unused template");

    repeat (4) @(negedge CLOCK_25);
    checkOutput("scoreboard_drained", sbQ.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule

// File: doc/voice_allocator.md
Name: voice_allocator

Overview:
Voice scheduler between the MIDI byte decoder and the synth engine. It accepts parsed note-on/note-off events, assigns each note to one of VOICES voice slots using keys_on and the envelope generators' voice_free, and steals the oldest voice when all are busy. It drives the per-voice key/velocity load strobes consumed by the pitch and envelope logic.

Parameters:
VOICES, 4, number of voice slots (power of 2, 1..64)
V_WIDTH, utils::clogb2(VOICES), voice index width
AGE_W, 8, per-voice age counter width

Ports:
CLOCK_25  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-high reset
ev_valid  input  1  event request; held until accepted
ev_ready  output  1  block idle and able to accept an event
ev_on  input  1  1 = note-on, 0 = note-off
ev_key  input  7  MIDI key number
ev_vel  input  7  MIDI velocity
voice_free  input  VOICES  1 = envelope of voice fully released
keys_on  output  VOICES  1 = voice currently holds a pressed key
note_on  output  1  one-cycle pulse: voice cur_key_adr loaded for start
note_off  output  1  one-cycle pulse: voice cur_key_adr released
cur_key_adr  output  V_WIDTH  target voice of the current pulse
cur_key_val  output  8  {1'b0, key} of the target voice
cur_vel_on  output  8  {1'b0, velocity} for note_on
cur_vel_off  output  8  {1'b0, velocity} for note_off
active_keys  output  V_WIDTH+1  population count of keys_on
off_note_error  output  1  one-cycle pulse: note-off matched no voice
stolen  output  1  one-cycle pulse coincident with note_on when a held voice was taken

Behaviour:
- Reset values: ev_ready=1; keys_on, active_keys, pulses, cur_* = 0; all key tags and ages = 0; state IDLE. Reset wins over any other event and aborts a scan in progress; no pulse is emitted for the aborted event.
- Per-voice state: key tag (7 b), age (AGE_W, saturating).
- Handshake: accepted when ev_valid & ev_ready. The event is latched, and ev_ready drops in the same edge.
- A note-on with ev_vel==0 is treated as note-off (MIDI running-status convention).
- FSM: IDLE -> SCAN -> ISSUE -> IDLE.
- IDLE: ev_ready=1. On accept, go to SCAN with idx=0.
- SCAN: examines one voice per cycle, idx 0..VOICES-1, and records candidates. Candidate priority for note-on:
  (1) voice with keys_on=1 and tag==key (retrigger same voice);
  (2) lowest idx with keys_on=0 and voice_free=1;
  (3) lowest idx with keys_on=0 (voice still in release);
  (4) steal: keys_on=1 with maximum age, ties to lowest idx.
  For note-off, the candidate is the lowest idx with keys_on=1 and tag==key.
- voice_free and keys_on are sampled at the scan cycle of each voice.
- After idx=VOICES-1, go to ISSUE.
- ISSUE (one cycle): registered outputs update. State returns to IDLE, so ev_ready=1 in the following cycle.
- Latency: accept at edge 0; note_on/note_off/off_note_error asserted in cycle VOICES+1; next accept possible at edge VOICES+2.
- Note-on issue: keys_on[v]=1, tag[v]=key, age[v]=0; every other voice with keys_on=1 increments age, saturating at 2^AGE_W-1. note_on=1. stolen=1 only for rule (4).
- Note-off issue, match found: keys_on[v]=0, note_off=1; the age is unchanged.
- Note-off issue, no match: off_note_error=1; no state change.
- cur_key_adr, cur_key_val, cur_vel_on and cur_vel_off hold their values until the next issue.
- active_keys is registered and updates in the same cycle as keys_on.
- Retrigger (rule 1) does not count as a steal, and active_keys is unchanged.
- With VOICES=1 the scan is one cycle, and every note-on to a busy voice is rule (1) or (4).

Optional Feature:
VOICE_STEAL_EN.
- Defined: rule (4) is active as above.
- Undefined: when rules (1)–(3) all fail, the note-on is dropped and no note_on is issued. The stolen output is replaced by a one-cycle drop pulse on the same port (tie-off 0 in all other cases), and no voice state changes.

Test Plan:
- Reset, then note-on key 60 vel 100, all voice_free=1 -> after VOICES+1 cycles note_on=1, cur_key_adr=0, cur_key_val=60, cur_vel_on=100, keys_on=0001, active_keys=1.
- Note-on keys 60,62,64,65 then 67 (VOICES=4, all voices held) -> 5th event steals voice 0 (oldest): stolen=1, cur_key_adr=0, cur_key_val=67, keys_on=1111; with VOICE_STEAL_EN undefined -> drop pulse instead, keys_on unchanged.
- Hold key 60 on voice 0, note-on key 60 vel 50 -> note_on on cur_key_adr=0, stolen=0, active_keys stays 1.
- Note-off key 62 when held on voice 1 -> note_off=1, cur_key_adr=1, keys_on[1]=0; repeat the same note-off -> off_note_error=1 only.
- Voices 0,1 released, voice_free=0010 -> next note-on goes to voice 1 (rule 2) rather than voice 0; note-on with vel 0 for a held key -> note_off.
- Assert reset during SCAN -> no pulse emitted, keys_on=0, ev_ready=1 in the cycle after reset deasserts.
